tick_wave_gen: RTL

Parametrised time-base generator: divides `clk` by a runtime-programmable period and produces a duty-controlled square wave plus a one-cycle end-of-period tick. It supports free-running square, tick-only and one-shot modes, a pause enable, and configuration-error flagging. After reset it comes up running a default configuration (50 MHz → 1 Hz, 50 % duty). It feeds the time/display counters and any block needing a slow enable.

---
 rtl/tick_wave_gen_if.sv | 43 ++++
 rtl/tick_wave_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tick_wave_gen_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tick_wave_gen_if
//  Description : Control/status bundle of the tick/wave time-base generator.
//                The master side drives the configuration strobe and fields
//                and observes the registered outputs; the slave side is the
//                generator itself.
//  Signals     : load    - latch period/high/mode and restart at count 0
//                en      - count enable, 0 pauses
//                mode    - 00 square, 01 tick-only, 10 one-shot, 11 reserved
//                period  - cycles per period (legal >= 2)
//                high    - cycles the wave is high per period
//                wave    - divided square wave
//                tick    - one-cycle pulse in the last cycle of a period
//                busy    - generator is running or paused
//                cfg_err - sticky flag for an illegal load
//  Revision    : 1.0  initial release
// ============================================================================
interface tick_wave_gen_if #(
    parameter int CNT_W = 26
);
    logic             load;
    logic             en;
    logic [1:0]       mode;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             wave;
    logic             tick;
    logic             busy;
    logic             cfg_err;

    modport master (
        output load, en, mode, period, high,
        input  wave, tick, busy, cfg_err
    );

    modport slave (
        input  load, en, mode, period, high,
        output wave, tick, busy, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/tick_wave_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tick_wave_gen
//  Description : Runtime-programmable time base. Divides clk by a latched
//                period and produces a duty-controlled square wave plus a
//                one-cycle end-of-period tick. Supports free-running square,
//                tick-only and one-shot modes, pausing via en, and a sticky
//                configuration-error flag.
//  Ports       : clk  - clock
//                clr  - asynchronous, active-high reset
//                bus  - tick_wave_gen_if.slave (load/en/mode/period/high in,
//                       wave/tick/busy/cfg_err out)
//  Parameters  : CNT_W      - width of counter, period and high
//                DEF_PERIOD - period loaded by clr (clk cycles)
//                DEF_HIGH   - high time loaded by clr (clk cycles)
//                AUTO_START - 1: running after clr, 0: idle after clr
//  Revision    : 1.0  initial release
// ============================================================================
module tick_wave_gen #(
    parameter int CNT_W      = 26,
    parameter int DEF_PERIOD = 50_000_000,
    parameter int DEF_HIGH   = 25_000_000,
    parameter int AUTO_START = 1
) (
    input  wire logic        clk,
    input  wire logic        clr,
    tick_wave_gen_if.slave   bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_MODE_SQUARE = 2'b00;
    localparam logic [1:0] c_MODE_TICK   = 2'b01;
    localparam logic [1:0] c_MODE_ONE    = 2'b10;
    localparam logic [1:0] c_MODE_RSVD   = 2'b11;

    localparam logic [CNT_W-1:0] c_ZERO        = '0;
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_TWO         = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_DEF_PERIOD  = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] c_DEF_HIGH    = CNT_W'(DEF_HIGH);
    localparam logic             c_AUTO        = (AUTO_START != 0);
    localparam logic             c_WAVE_RST    = (AUTO_START != 0) && (DEF_HIGH > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam state_t c_STATE_RST = c_AUTO ? S_RUN : S_IDLE;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic [1:0]       r_mode;
    logic             r_wave;
    logic             r_tick;
    logic             r_busy;
    logic             r_cfg_err;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_period_nx;
    logic [CNT_W-1:0] w_high_nx;
    logic [1:0]       w_mode_nx;
    logic             w_err_nx;
    logic             w_legal;
    logic             w_last;
    logic             w_active_nx;
    logic             w_wave_nx;
    logic             w_tick_nx;

    assign w_legal = (bus.period >= c_TWO) && (bus.mode != c_MODE_RSVD);

    // ">=" rather than "==" so a counter that is somehow beyond the end of
    // the period still wraps instead of running away.
    assign w_last  = (r_cnt >= (r_period - c_ONE));

    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_period_nx = r_period;
        w_high_nx   = r_high;
        w_mode_nx   = r_mode;
        w_err_nx    = r_cfg_err;

        if (bus.load) begin
            // load outranks both en and the counter wrap
            w_cnt_nx = c_ZERO;
            if (w_legal) begin
                w_period_nx = bus.period;
                w_high_nx   = bus.high;
                w_mode_nx   = bus.mode;
                w_err_nx    = 1'b0;
                w_state_nx  = bus.en ? S_RUN : S_PAUSE;
            end else begin
                w_err_nx    = 1'b1;
                w_state_nx  = S_IDLE;
            end
        end else begin
            case (r_state)
                S_RUN, S_PAUSE: begin
                    // Any edge with en=1 advances the count, including the
                    // one that leaves PAUSE, so a pause of N cycles delays
                    // the period by exactly N cycles.
                    if (bus.en) begin
                        w_state_nx = S_RUN;
                        if (w_last) begin
                            w_cnt_nx = c_ZERO;
                            if (r_mode == c_MODE_ONE) begin
                                w_state_nx = S_DONE;
                            end
                        end else begin
                            w_cnt_nx = r_cnt + c_ONE;
                        end
                    end else begin
                        w_state_nx = S_PAUSE;
                    end
                end
                default: begin
                    // IDLE and DONE only leave through load
                    w_cnt_nx = c_ZERO;
                end
            endcase
        end
    end

    // Outputs are computed from the next-state values so that every output
    // register describes the same post-edge state as cnt and state.
    assign w_active_nx = (w_state_nx == S_RUN) || (w_state_nx == S_PAUSE);

    assign w_wave_nx   = w_active_nx
                       && (w_mode_nx != c_MODE_TICK)
                       && (w_cnt_nx < w_high_nx);

    // RUN is only ever entered on an edge with en=1, so the post-edge RUN
    // state already carries the "en=1" qualifier of the tick condition.
    assign w_tick_nx   = (w_state_nx == S_RUN)
                       && (w_cnt_nx == (w_period_nx - c_ONE));

    // ------------------------------------------------------------------
    // State machine and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state   <= c_STATE_RST;
            r_cnt     <= c_ZERO;
            r_period  <= c_DEF_PERIOD;
            r_high    <= c_DEF_HIGH;
            r_mode    <= c_MODE_SQUARE;
            r_wave    <= c_WAVE_RST;
            r_tick    <= 1'b0;
            r_busy    <= c_AUTO;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_period  <= w_period_nx;
            r_high    <= w_high_nx;
            r_mode    <= w_mode_nx;
            r_wave    <= w_wave_nx;
            r_tick    <= w_tick_nx;
            r_busy    <= w_active_nx;
            r_cfg_err <= w_err_nx;
        end
    end

    assign bus.wave    = r_wave;
    assign bus.tick    = r_tick;
    assign bus.busy    = r_busy;
    assign bus.cfg_err = r_cfg_err;

endmodule
`default_nettype wire
